// File: rtl/core_mem_arb_pkg.sv
// core_mem_arb_pkg: shared widths and encodings for the core memory arbiter.
//   CORE_PC_WIDTH / CORE_XLEN : fetch-address and data-path widths
//   arb_state_e               : arbiter FSM state encoding (2-bit)
//   arb_owner_e               : owner of the in-flight transaction
package core_mem_arb_pkg;

   localparam int CORE_PC_WIDTH         = 32;
   localparam int CORE_XLEN             = 32;
   localparam int CORE_MEM_WMASK_WIDTH  = 8;

   typedef enum logic [1:0] {
      CORE_MEM_ARB_IDLE  = 2'd0,
      CORE_MEM_ARB_ISSUE = 2'd1,
      CORE_MEM_ARB_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      CORE_MEM_ARB_OWN_IFU = 1'b0,
      CORE_MEM_ARB_OWN_LSU = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/core_mem_arb_prio.sv
// core_mem_arb_prio: grant selection between IFU and LSU.
//   idle      in  arbiter is in IDLE and may grant
//   ifu_valid in  IFU request pending
//   lsu_valid in  LSU request pending
//   grant_ifu out IFU wins this cycle (before any flush masking)
//   grant_lsu out LSU wins this cycle
// With CORE_MEM_ARB_STARVE_EN defined, a saturating counter of LSU grants
// taken while IFU waits hands the next grant to IFU once it reaches
// STARVE_LIMIT; otherwise LSU has strict priority and clk/rst are absent.
module core_mem_arb_prio
   import core_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
`ifdef CORE_MEM_ARB_STARVE_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic idle,
   input  logic ifu_valid,
   input  logic lsu_valid,
   output logic grant_ifu,
   output logic grant_lsu
);

`ifdef CORE_MEM_ARB_STARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;
   logic       ifu_turn;

   assign ifu_turn = (starve_cnt_q == LIMIT) & ifu_valid;

   always_comb begin
      grant_lsu    = idle & lsu_valid & ~ifu_turn;
      grant_ifu    = idle & ifu_valid & ~grant_lsu;
      starve_cnt_d = starve_cnt_q;
      if (idle) begin
         if (grant_lsu & ifu_valid) begin
            if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
         end else if (grant_ifu | ~ifu_valid) begin
            starve_cnt_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_cnt_q <= 4'd0;
      else     starve_cnt_q <= starve_cnt_d;
   end
`else
   assign grant_lsu = idle & lsu_valid;
   assign grant_ifu = idle & ifu_valid & ~lsu_valid;
`endif

endmodule

// File: rtl/core_mem_arb.sv
// core_mem_arb: shares one memory port between IFU fetch and the LSU.
// One transaction outstanding; request payload is registered, the response
// path is a combinational pass-through steered to the owner.
//   clk, rst (async, active-high), flush (commit pipeline flush pulse)
//   ifu_req_*/ifu_rsp_* : IFU request/response valid-ready channels
//   lsu_req_*/lsu_rsp_* : LSU request/response valid-ready channels
//   mem_req_*/mem_rsp_* : memory-side request/response channels
// Optional feature macro: CORE_MEM_ARB_STARVE_EN (anti-starvation counter).
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | mem_req_valid high until mem_req_ready
// WAIT  | response steered to owner (or dropped after IFU flush)
module core_mem_arb
   import core_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            ifu_req_valid,
   output logic                            ifu_req_ready,
   input  logic [CORE_PC_WIDTH-1:0]        ifu_req_addr,
   output logic                            ifu_rsp_valid,
   input  logic                            ifu_rsp_ready,
   output logic [CORE_XLEN-1:0]            ifu_rsp_data,
   input  logic                            lsu_req_valid,
   output logic                            lsu_req_ready,
   input  logic                            lsu_req_wen,
   input  logic [CORE_XLEN-1:0]            lsu_req_addr,
   input  logic [CORE_XLEN-1:0]            lsu_req_wdata,
   input  logic [CORE_MEM_WMASK_WIDTH-1:0] lsu_req_wmask,
   output logic                            lsu_rsp_valid,
   input  logic                            lsu_rsp_ready,
   output logic [CORE_XLEN-1:0]            lsu_rsp_data,
   output logic                            mem_req_valid,
   input  logic                            mem_req_ready,
   output logic                            mem_req_wen,
   output logic [CORE_XLEN-1:0]            mem_req_addr,
   output logic [CORE_XLEN-1:0]            mem_req_wdata,
   output logic [CORE_MEM_WMASK_WIDTH-1:0] mem_req_wmask,
   input  logic                            mem_rsp_valid,
   output logic                            mem_rsp_ready,
   input  logic [CORE_XLEN-1:0]            mem_rsp_data
);

   arb_state_e                      state_q, state_d;
   arb_owner_e                      owner_q, owner_d;
   logic                            wen_q, wen_d;
   logic [CORE_XLEN-1:0]            addr_q, addr_d;
   logic [CORE_XLEN-1:0]            wdata_q, wdata_d;
   logic [CORE_MEM_WMASK_WIDTH-1:0] wmask_q, wmask_d;
   logic                            drop_q, drop_d;

   logic idle, grant_ifu, grant_lsu;
   logic ifu_hs, lsu_hs, in_wait, drop_set, drop_now, rsp_hs;

   assign idle = (state_q == CORE_MEM_ARB_IDLE);

   core_mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
`ifdef CORE_MEM_ARB_STARVE_EN
      .clk       (clk),
      .rst       (rst),
`endif
      .idle      (idle),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   assign ifu_req_ready = grant_ifu & ~flush;
   assign lsu_req_ready = grant_lsu;
   assign ifu_hs        = ifu_req_valid & ifu_req_ready;
   assign lsu_hs        = lsu_req_valid & lsu_req_ready;

   assign in_wait  = (state_q == CORE_MEM_ARB_WAIT);
   // A flush in the same cycle as the response already suppresses it.
   assign drop_set = flush & ~idle & (owner_q == CORE_MEM_ARB_OWN_IFU);
   assign drop_now = drop_q | drop_set;

   assign mem_req_valid = (state_q == CORE_MEM_ARB_ISSUE);
   assign mem_req_wen   = wen_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

   assign ifu_rsp_valid = in_wait & (owner_q == CORE_MEM_ARB_OWN_IFU) & ~drop_now & mem_rsp_valid;
   assign lsu_rsp_valid = in_wait & (owner_q == CORE_MEM_ARB_OWN_LSU) & mem_rsp_valid;
   assign ifu_rsp_data  = mem_rsp_data;
   assign lsu_rsp_data  = mem_rsp_data;
   assign mem_rsp_ready = in_wait & ((owner_q == CORE_MEM_ARB_OWN_LSU) ? lsu_rsp_ready
                                                                       : (drop_now | ifu_rsp_ready));
   assign rsp_hs        = mem_rsp_valid & mem_rsp_ready;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      drop_d  = drop_q;
      case (state_q)
         CORE_MEM_ARB_IDLE: begin
            if (lsu_hs) begin
               owner_d = CORE_MEM_ARB_OWN_LSU;
               wen_d   = lsu_req_wen;
               addr_d  = lsu_req_addr;
               wdata_d = lsu_req_wdata;
               wmask_d = lsu_req_wmask;
               state_d = CORE_MEM_ARB_ISSUE;
            end else if (ifu_hs) begin
               owner_d = CORE_MEM_ARB_OWN_IFU;
               wen_d   = 1'b0;
               addr_d  = CORE_XLEN'(ifu_req_addr);
               wdata_d = '0;
               wmask_d = '0;
               state_d = CORE_MEM_ARB_ISSUE;
            end
         end
         CORE_MEM_ARB_ISSUE: begin
            if (drop_set) drop_d = 1'b1;
            if (mem_req_ready) state_d = CORE_MEM_ARB_WAIT;
         end
         CORE_MEM_ARB_WAIT: begin
            if (rsp_hs) begin
               drop_d  = 1'b0;
               state_d = CORE_MEM_ARB_IDLE;
            end else if (drop_set) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = CORE_MEM_ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CORE_MEM_ARB_IDLE;
         owner_q <= CORE_MEM_ARB_OWN_IFU;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         drop_q  <= drop_d;
      end
   end

endmodule
